// File: rtl/wb_port_sched_if.sv
// wb_port_sched_if
//   Writeback-side bundle between the W pipeline register / register file
//   and the writeback port scheduler. Signal suffixes are from the point of
//   view of the scheduler (slave modport).
//   W_stat_i   W-stage status (1 AOK, 2 HLT, 3 ADR, 4 INS)
//   W_icode_i  W-stage icode (1 = nop/bubble)
//   W_valE_i   ALU result
//   W_valM_i   memory read result
//   W_dstE_i   E destination reg id, 4'hF = none
//   W_dstM_i   M destination reg id, 4'hF = none
//   rf_we_o    register-file write enable
//   rf_addr_o  register-file write address
//   rf_data_o  register-file write data
//   wb_stall_o hold W register and all upstream stages
interface wb_port_sched_if #(
   parameter int unsigned DW = 64
);
   logic [3:0]    W_stat_i;
   logic [3:0]    W_icode_i;
   logic [DW-1:0] W_valE_i;
   logic [DW-1:0] W_valM_i;
   logic [3:0]    W_dstE_i;
   logic [3:0]    W_dstM_i;
   logic          rf_we_o;
   logic [3:0]    rf_addr_o;
   logic [DW-1:0] rf_data_o;
   logic          wb_stall_o;

   modport master (
      output W_stat_i, W_icode_i, W_valE_i, W_valM_i, W_dstE_i, W_dstM_i,
      input  rf_we_o, rf_addr_o, rf_data_o, wb_stall_o
   );

   modport slave (
      input  W_stat_i, W_icode_i, W_valE_i, W_valM_i, W_dstE_i, W_dstM_i,
      output rf_we_o, rf_addr_o, rf_data_o, wb_stall_o
   );
endinterface

// File: rtl/wb_port_sched.sv
// wb_port_sched
//   Schedules Y86 writeback onto a single-write-port register file. An
//   instruction writing two distinct registers takes two cycles (E first,
//   then M) and stalls upstream during the first. Also latches the
//   architectural status, halts on any non-AOK status and counts retired
//   instructions (saturating).
//   clk_i          clock, rising edge
//   rst_i          synchronous reset, active-high
//   wb             writeback bundle (W_* in, rf_* / wb_stall out)
//   cpu_stat_o     architectural status, registered
//   halted_o       high once halted, registered
//   retire_cnt_o   retired-instruction count, registered, saturating
module wb_port_sched #(
   parameter int unsigned DW    = 64,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   wb_port_sched_if.slave   wb,
   output logic [3:0]       cpu_stat_o,
   output logic             halted_o,
   output logic [CNT_W-1:0] retire_cnt_o
);

   localparam logic [3:0] STAT_AOK  = 4'd1;
   localparam logic [3:0] REG_NONE  = 4'hF;
   localparam logic [3:0] ICODE_NOP = 4'h1;

   typedef enum logic [1:0] {
      S_READY,
      S_SECOND,
      S_HALT
   } state_t;

   state_t           state_q,     state_d;
   logic [3:0]       pend_addr_q, pend_addr_d;
   logic [DW-1:0]    pend_data_q, pend_data_d;
   logic [3:0]       stat_q,      stat_d;
   logic             halted_q,    halted_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic             retire;
   logic             e_valid;
   logic             m_valid;

   assign e_valid = (wb.W_dstE_i != REG_NONE);
   assign m_valid = (wb.W_dstM_i != REG_NONE);

   always_comb begin
      state_d        = state_q;
      pend_addr_d    = pend_addr_q;
      pend_data_d    = pend_data_q;
      stat_d         = stat_q;
      halted_d       = halted_q;
      retire         = 1'b0;
      wb.rf_we_o     = 1'b0;
      wb.rf_addr_o   = '0;
      wb.rf_data_o   = '0;
      wb.wb_stall_o  = 1'b0;

      unique case (state_q)
         S_READY: begin
            if (wb.W_stat_i != STAT_AOK) begin
               stat_d   = wb.W_stat_i;
               halted_d = 1'b1;
               state_d  = S_HALT;
            end else if (e_valid && m_valid && (wb.W_dstE_i != wb.W_dstM_i)) begin
               // E goes out now; M is parked and written next cycle.
               wb.rf_we_o    = 1'b1;
               wb.rf_addr_o  = wb.W_dstE_i;
               wb.rf_data_o  = wb.W_valE_i;
               wb.wb_stall_o = 1'b1;
               pend_addr_d   = wb.W_dstM_i;
               pend_data_d   = wb.W_valM_i;
               state_d       = S_SECOND;
            end else begin
               // Same destination on both ports: the M value wins.
               if (m_valid) begin
                  wb.rf_we_o   = 1'b1;
                  wb.rf_addr_o = wb.W_dstM_i;
                  wb.rf_data_o = wb.W_valM_i;
               end else if (e_valid) begin
                  wb.rf_we_o   = 1'b1;
                  wb.rf_addr_o = wb.W_dstE_i;
                  wb.rf_data_o = wb.W_valE_i;
               end
               retire = (wb.W_icode_i != ICODE_NOP);
            end
         end
         S_SECOND: begin
            wb.rf_we_o   = 1'b1;
            wb.rf_addr_o = pend_addr_q;
            wb.rf_data_o = pend_data_q;
            retire       = 1'b1;
            state_d      = S_READY;
         end
         S_HALT: begin
         end
         default: begin
            state_d = S_READY;
         end
      endcase

      cnt_d = (retire && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

      // Reset suppresses the port so a parked M write is dropped, not issued.
      if (rst_i) begin
         wb.rf_we_o    = 1'b0;
         wb.wb_stall_o = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_READY;
         pend_addr_q <= '0;
         pend_data_q <= '0;
         stat_q      <= STAT_AOK;
         halted_q    <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         pend_addr_q <= pend_addr_d;
         pend_data_q <= pend_data_d;
         stat_q      <= stat_d;
         halted_q    <= halted_d;
         cnt_q       <= cnt_d;
      end
   end

   assign cpu_stat_o   = stat_q;
   assign halted_o     = halted_q;
   assign retire_cnt_o = cnt_q;

endmodule

// File: tb/tb_wb_port_sched.sv
// tb_wb_port_sched
//   Directed and randomized stimulus for wb_port_sched. Expected behaviour
//   comes from an instruction-level model: each instruction expands into a
//   list of register writes issued one per cycle, with stall high on all but
//   the last, and retires once after its final write.
module tb_wb_port_sched;

   localparam int unsigned DW    = 64;
   localparam int unsigned CNT_W = 4;
   localparam int          CNT_MAX = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst;
   logic [3:0]       cpu_stat;
   logic             halted;
   logic [CNT_W-1:0] retire_cnt;

   int checks = 0;
   int errors = 0;

   int         m_cnt;
   logic [3:0] m_stat;
   logic       m_halted;

   wb_port_sched_if #(.DW(DW)) bus ();

   wb_port_sched #(.DW(DW), .CNT_W(CNT_W)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .wb           (bus),
      .cpu_stat_o   (cpu_stat),
      .halted_o     (halted),
      .retire_cnt_o (retire_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   task automatic drive(input logic [3:0] st, input logic [3:0] ic,
                        input logic [3:0] de, input logic [63:0] ve,
                        input logic [3:0] dm, input logic [63:0] vm);
      bus.W_stat_i  = st;
      bus.W_icode_i = ic;
      bus.W_dstE_i  = de;
      bus.W_valE_i  = ve;
      bus.W_dstM_i  = dm;
      bus.W_valM_i  = vm;
   endtask

   task automatic scramble();
      drive(4'($urandom), 4'($urandom), 4'($urandom), rnd64(), 4'($urandom), rnd64());
   endtask

   task automatic check_regs(input string tag);
      check({tag, ".cnt"},    64'(retire_cnt), 64'(m_cnt));
      check({tag, ".stat"},   64'(cpu_stat),   64'(m_stat));
      check({tag, ".halted"}, 64'(halted),     64'(m_halted));
   endtask

   task automatic model_reset();
      m_cnt    = 0;
      m_stat   = 4'd1;
      m_halted = 1'b0;
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         scramble();
         #2;
         check("rst.we",    64'(bus.rf_we_o),    64'(0));
         check("rst.stall", 64'(bus.wb_stall_o), 64'(0));
         tick();
      end
      rst = 1'b0;
      model_reset();
      check_regs("rst");
   endtask

   // Present one instruction in W and follow it until it leaves W.
   task automatic run_instr(input string tag,
                            input logic [3:0] st, input logic [3:0] ic,
                            input logic [3:0] de, input logic [63:0] ve,
                            input logic [3:0] dm, input logic [63:0] vm);
      logic [3:0]  wa[$];
      logic [63:0] wd[$];
      bit          retire;
      drive(st, ic, de, ve, dm, vm);
      if (m_halted || st != 4'd1) begin
         #2;
         check({tag, ".we"},    64'(bus.rf_we_o),    64'(0));
         check({tag, ".stall"}, 64'(bus.wb_stall_o), 64'(0));
         tick();
         if (!m_halted) begin
            m_halted = 1'b1;
            m_stat   = st;
         end
         check_regs(tag);
      end else begin
         if (de != 4'hF && dm != 4'hF && de != dm) begin
            wa.push_back(de); wd.push_back(ve);
            wa.push_back(dm); wd.push_back(vm);
         end else if (dm != 4'hF) begin
            wa.push_back(dm); wd.push_back(vm);
         end else if (de != 4'hF) begin
            wa.push_back(de); wd.push_back(ve);
         end
         retire = (ic != 4'h1) || (wa.size() == 2);
         if (wa.size() == 0) begin
            #2;
            check({tag, ".we"},    64'(bus.rf_we_o),    64'(0));
            check({tag, ".stall"}, 64'(bus.wb_stall_o), 64'(0));
            tick();
         end else begin
            for (int i = 0; i < wa.size(); i++) begin
               #2;
               check({tag, ".we"},    64'(bus.rf_we_o),    64'(1));
               check({tag, ".addr"},  64'(bus.rf_addr_o),  64'(wa[i]));
               check({tag, ".data"},  bus.rf_data_o,       wd[i]);
               check({tag, ".stall"}, 64'(bus.wb_stall_o), 64'(i + 1 < wa.size()));
               tick();
               if (i + 1 < wa.size()) begin
                  check({tag, ".midcnt"}, 64'(retire_cnt), 64'(m_cnt));
                  scramble();
               end
            end
         end
         if (retire && m_cnt < CNT_MAX) m_cnt++;
         check_regs(tag);
      end
   endtask

   initial begin
      logic [3:0] st, ic, de, dm;
      rst = 1'b1;
      drive(4'd1, 4'h1, 4'hF, '0, 4'hF, '0);

      // Reset held two cycles.
      do_reset(2);

      // Directed cases.
      run_instr("single_e", 4'd1, 4'h6, 4'd3, 64'h55, 4'hF, 64'h0);
      run_instr("dual",     4'd1, 4'hB, 4'd4, 64'h100, 4'd7, 64'hAB);
      run_instr("same_dst", 4'd1, 4'h5, 4'd4, 64'h10, 4'd4, 64'h20);
      run_instr("only_m",   4'd1, 4'h5, 4'hF, 64'h11, 4'd9, 64'h22);
      run_instr("no_dst",   4'd1, 4'h0, 4'hF, 64'h33, 4'hF, 64'h44);
      run_instr("bubble",   4'd1, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0);
      run_instr("adr",      4'd3, 4'h6, 4'd2, 64'h77, 4'hF, 64'h0);
      run_instr("post_halt1", 4'd1, 4'h6, 4'd5, 64'h99, 4'hF, 64'h0);
      run_instr("post_halt2", 4'd1, 4'hB, 4'd5, 64'h9, 4'd6, 64'h8);

      // Reset landing on the second cycle of a dual write.
      do_reset(1);
      drive(4'd1, 4'hB, 4'd2, 64'hAAAA, 4'd8, 64'hBBBB);
      #2;
      check("rsec.we0",    64'(bus.rf_we_o),    64'(1));
      check("rsec.stall0", 64'(bus.wb_stall_o), 64'(1));
      tick();
      rst = 1'b1;
      #2;
      check("rsec.we1",    64'(bus.rf_we_o),    64'(0));
      check("rsec.stall1", 64'(bus.wb_stall_o), 64'(0));
      tick();
      rst = 1'b0;
      model_reset();
      check_regs("rsec");
      run_instr("rsec.next", 4'd1, 4'h6, 4'd1, 64'h1234, 4'hF, 64'h0);

      // Saturation of the retire counter.
      for (int i = 0; i < CNT_MAX + 4; i++)
         run_instr("sat", 4'd1, 4'h6, 4'($urandom_range(0, 14)), rnd64(), 4'hF, 64'h0);

      // Randomized instruction stream.
      do_reset(1);
      for (int n = 0; n < 400; n++) begin
         if (m_halted && $urandom_range(0, 3) == 0)
            do_reset(1 + $urandom_range(0, 1));
         st = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(2, 4)) : 4'd1;
         ic = 4'($urandom_range(0, 11));
         de = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 14));
         dm = ($urandom_range(0, 2) == 0) ? 4'hF :
              ($urandom_range(0, 5) == 0) ? de : 4'($urandom_range(0, 14));
         run_instr("rand", st, ic, de, rnd64(), dm, rnd64());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
